t05_spi_responder: RTL and testbench

- SPI mode-0 responder (target) for the far end of the team's SPI master link, whose SCLK comes from the SPI clock divider.
- Oversamples the external sclk, cs_n and mosi on the local system clock and deserialises MOSI bytes, MSB first.
- Serialises a one-entry-buffered transmit byte onto MISO.
- Used for loopback bring-up of the master and as a bench peer.

---
 rtl/t05_spi_responder.sv | 104 ++++++++++
 tb/tb_t05_spi_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/t05_spi_responder.sv
// t05_spi_responder: SPI mode-0 target with oversampled inputs and a one-entry transmit holding register
module t05_spi_responder #(
    parameter int DATA_W = 8
) (
    input  logic              current_clock_signal,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t            state_q;
    logic [2:0]        sclk_q, cs_q;
    logic [1:0]        mosi_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] tx_shift_q, hold_q, rx_data_q, rx_shift_d, load_word;
    logic [DATA_W-2:0] rx_shift_q;
    logic              full_q, rx_valid_q, underrun_q;
    logic              sclk_rise, sclk_fall, cs_rise, cs_fall, last_bit;
    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign cs_rise     = cs_q[1] & ~cs_q[2];
    assign cs_fall     = ~cs_q[1] & cs_q[2];
    assign rx_shift_d  = {rx_shift_q, mosi_q[1]};
    assign load_word   = full_q ? hold_q : '1;
    assign last_bit    = bit_cnt_q == CW'(DATA_W - 1);
    assign miso        = (state_q == ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b1;
    assign busy        = state_q == ACTIVE;
    assign tx_ready    = ~full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    // Two-flop synchronisers plus a third copy of sclk/cs_n for edge detection
    always_ff @(posedge current_clock_signal or posedge reset) begin
        if (reset) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end
    // Transfer FSM, shift registers and holding register; a load at a word start never sees a same-cycle write
    always_ff @(posedge current_clock_signal or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            if (tx_valid && !full_q) begin
                hold_q <= tx_data;
                full_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_q    <= ACTIVE;
                    bit_cnt_q  <= '0;
                    tx_shift_q <= load_word;
                    if (full_q) full_q <= 1'b0;
                    else underrun_q <= 1'b1;
                end
                ACTIVE: if (cs_rise) begin
                    state_q   <= IDLE;
                    bit_cnt_q <= '0;
                end else if (sclk_rise) begin
                    rx_shift_q <= rx_shift_d[DATA_W-2:0];
                    bit_cnt_q  <= last_bit ? '0 : bit_cnt_q + CW'(1);
                    if (last_bit) begin
                        rx_data_q  <= rx_shift_d;
                        rx_valid_q <= 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        tx_shift_q <= load_word;
                        if (full_q) full_q <= 1'b0;
                        else underrun_q <= 1'b1;
                    end else begin
                        tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_t05_spi_responder.sv
// tb_t05_spi_responder: acts as SPI mode-0 master and checks the responder against a transfer-level model
module tb_t05_spi_responder;
    typedef logic [7:0] w4_t [4];
    typedef struct {
        logic       wr;
        logic [7:0] txw;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        int         exp_un;
    } vec_t;

    logic       clk = 0, rst = 1, sclk = 0, cs_n = 1, mosi = 0, tx_valid = 0;
    logic [7:0] tx_data = 0;
    logic       miso, tx_ready, rx_valid, busy, tx_underrun;
    logic [7:0] rx_data;
    int         checks = 0, passes = 0, un_cnt = 0, hp = 4;
    logic [7:0] rx_q[$];
    logic       m_full = 0;
    logic [7:0] m_val = 0;
    int         m_un = 0;

    t05_spi_responder #(.DATA_W(8)) dut (
        .current_clock_signal(clk), .reset(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_underrun) un_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Word start: the held word if one is buffered, otherwise all ones with an underrun
    function automatic logic [7:0] m_load();
        if (m_full) begin
            m_full = 0;
            return m_val;
        end
        m_un++;
        return 8'hFF;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] v);
        chk("tx_ready_before_write", {31'd0, tx_ready}, {31'd0, ~m_full});
        tx_data = v;
        tx_valid = 1;
        cyc(1);
        tx_valid = 0;
        m_full = 1;
        m_val = v;
    endtask

    task automatic bit_xfer(input logic b, output logic m);
        mosi = b;
        cyc(hp);
        m = miso;
        sclk = 1;
        cyc(hp);
        sclk = 0;
    endtask

    task automatic frame(input int n, input w4_t mo, input int last_bits, input logic [3:0] rv,
                         input w4_t rf, output w4_t mi, output w4_t emi, output int eun);
        logic [7:0] cur;
        logic       b;
        int         nb;
        m_un = 0;
        mi = '{default: 8'h00};
        emi = '{default: 8'h00};
        cs_n = 0;
        cur = m_load();
        cyc(2);
        for (int w = 0; w < n; w++) begin
            nb = (w == n - 1) ? last_bits : 8;
            emi[w] = cur;
            for (int i = 0; i < nb; i++) begin
                bit_xfer(mo[w][7-i], b);
                mi[w][7-i] = b;
                if (i == 0 && rv[w]) tx_write(rf[w]);
            end
            if (nb == 8) cur = m_load();
        end
        cyc(hp);
        cs_n = 1;
        cyc(8);
        eun = m_un;
    endtask

    vec_t tbl[4];
    w4_t  mo, rf, mi, emi;
    int   un0, eun, n;
    logic [3:0] rv;
    logic b;

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
        tbl[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 2};
        tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1};
        tbl[3] = '{1'b1, 8'hC3, 8'h81, 8'hC3, 1};
        rf = '{default: 8'h00};
        cyc(3);
        chk("rst_miso", {31'd0, miso}, 1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 1);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_underrun", {31'd0, tx_underrun}, 0);
        rst = 0;
        cyc(2);
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom);
            sclk = ~sclk;
            cyc(4);
            chk("idle_miso", {31'd0, miso}, 1);
            chk("idle_busy", {31'd0, busy}, 0);
        end
        sclk = 0;
        cyc(4);
        chk("idle_rx_count", rx_q.size(), 0);
        chk("idle_underruns", un_cnt, 0);
        chk("idle_tx_ready", {31'd0, tx_ready}, 1);

        foreach (tbl[k]) begin
            if (tbl[k].wr) begin
                tx_write(tbl[k].txw);
                chk("tbl_tx_ready_full", {31'd0, tx_ready}, 0);
            end
            un0 = un_cnt;
            rx_q.delete();
            mo = '{tbl[k].mo, 8'h00, 8'h00, 8'h00};
            frame(1, mo, 8, 4'b0000, rf, mi, emi, eun);
            chk("tbl_miso_word", {24'd0, mi[0]}, {24'd0, tbl[k].exp_mi});
            chk("tbl_rx_count", rx_q.size(), 1);
            chk("tbl_rx_data", {24'd0, rx_data}, {24'd0, tbl[k].mo});
            chk("tbl_underruns", un_cnt - un0, tbl[k].exp_un);
            chk("tbl_tx_ready_after", {31'd0, tx_ready}, 1);
            chk("tbl_idle_miso", {31'd0, miso}, 1);
        end

        tx_write(8'h81);
        un0 = un_cnt;
        rx_q.delete();
        mo = '{8'h11, 8'h22, 8'h00, 8'h00};
        rf = '{8'h42, 8'h00, 8'h00, 8'h00};
        frame(2, mo, 8, 4'b0001, rf, mi, emi, eun);
        chk("b2b_miso0", {24'd0, mi[0]}, 32'h81);
        chk("b2b_miso1", {24'd0, mi[1]}, 32'h42);
        chk("b2b_rx_count", rx_q.size(), 2);
        chk("b2b_rx0", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 'x, 32'h11);
        chk("b2b_rx1", (rx_q.size() > 1) ? {24'd0, rx_q[1]} : 'x, 32'h22);
        chk("b2b_underruns", un_cnt - un0, 1);

        un0 = un_cnt;
        rx_q.delete();
        mo = '{8'hF0, 8'h00, 8'h00, 8'h00};
        frame(1, mo, 5, 4'b0000, rf, mi, emi, eun);
        chk("abort_rx_count", rx_q.size(), 0);
        chk("abort_rx_data", {24'd0, rx_data}, 32'h22);
        chk("abort_miso", {24'd0, mi[0]}, 32'hF8);
        chk("abort_underruns", un_cnt - un0, 1);
        mo = '{8'h0F, 8'h00, 8'h00, 8'h00};
        frame(1, mo, 8, 4'b0000, rf, mi, emi, eun);
        chk("after_abort_rx_count", rx_q.size(), 1);
        chk("after_abort_rx_data", {24'd0, rx_data}, 32'h0F);

        cs_n = 0;
        void'(m_load());
        cyc(2);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, b);
        tx_write(8'h77);
        rst = 1;
        cyc(1);
        chk("midrst_miso", {31'd0, miso}, 1);
        chk("midrst_tx_ready", {31'd0, tx_ready}, 1);
        chk("midrst_rx_data", {24'd0, rx_data}, 0);
        chk("midrst_rx_valid", {31'd0, rx_valid}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_underrun", {31'd0, tx_underrun}, 0);
        cs_n = 1;
        sclk = 0;
        m_full = 0;
        cyc(1);
        rst = 0;
        cyc(5);
        un0 = un_cnt;
        rx_q.delete();
        mo = '{8'h99, 8'h00, 8'h00, 8'h00};
        frame(1, mo, 8, 4'b0000, rf, mi, emi, eun);
        chk("postrst_rx_count", rx_q.size(), 1);
        chk("postrst_rx_data", {24'd0, rx_data}, 32'h99);
        chk("postrst_miso", {24'd0, mi[0]}, 32'hFF);
        chk("postrst_underruns", un_cnt - un0, 2);

        for (int t = 0; t < 15; t++) begin
            hp = $urandom_range(4, 6);
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            n = $urandom_range(1, 3);
            rv = 4'($urandom);
            for (int w = 0; w < 4; w++) begin
                mo[w] = 8'($urandom);
                rf[w] = 8'($urandom);
            end
            un0 = un_cnt;
            rx_q.delete();
            frame(n, mo, 8, rv, rf, mi, emi, eun);
            for (int w = 0; w < n; w++) begin
                chk("rnd_miso", {24'd0, mi[w]}, {24'd0, emi[w]});
                chk("rnd_rx", (w < rx_q.size()) ? {24'd0, rx_q[w]} : 'x, {24'd0, mo[w]});
            end
            chk("rnd_rx_count", rx_q.size(), n);
            chk("rnd_underruns", un_cnt - un0, eun);
            chk("rnd_rx_data", {24'd0, rx_data}, {24'd0, mo[n-1]});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
